// File: rtl/load_gather_unit.sv
// load_gather_unit: banked data-memory read path for scalar and 4-lane vector loads.
// Lanes that collide on a bank are serialized, lowest lane first.
// Ports:
//   clk, nrst                      clock, async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   is_vltype, load_select,        request kind, scalar size/sign,
//   byte_offset, addr0..addr3      scalar byte position, lane addresses
//   bank_rd*, bank_addr*           per-bank read strobe and in-bank address
//   bank_rdata*                    per-bank read data, one cycle after strobe
//   resp_valid, resp_err,          one-cycle response pulse, misaligned flag,
//   resp_data0..resp_data3         response words (held until next response)
module load_gather_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_vltype,
  input  logic [2:0]        load_select,
  input  logic [1:0]        byte_offset,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic              bank_rd0,
  output logic              bank_rd1,
  output logic              bank_rd2,
  output logic              bank_rd3,
  output logic [ADDR_W-3:0] bank_addr0,
  output logic [ADDR_W-3:0] bank_addr1,
  output logic [ADDR_W-3:0] bank_addr2,
  output logic [ADDR_W-3:0] bank_addr3,
  input  logic [31:0]       bank_rdata0,
  input  logic [31:0]       bank_rdata1,
  input  logic [31:0]       bank_rdata2,
  input  logic [31:0]       bank_rdata3,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_data0,
  output logic [31:0]       resp_data1,
  output logic [31:0]       resp_data2,
  output logic [31:0]       resp_data3
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] la [4];
  logic              vec_q;
  logic [2:0]        lsel_q;
  logic [1:0]        off_q;
  logic [3:0]        pend, pend_nx, grant;
  logic [3:0]        iss_v;
  logic [1:0]        iss_bank [4];
  logic [31:0]       lane [4];
  logic [31:0]       lane_nx [4];
  logic [31:0]       rdata [4];
  logic [31:0]       rsp [4];
  logic              rd_v [4];
  logic [ADDR_W-3:0] baddr [4];
  logic              accept, mis;
  logic [31:0]       sh, ext;

  assign rdata[0] = bank_rdata0;
  assign rdata[1] = bank_rdata1;
  assign rdata[2] = bank_rdata2;
  assign rdata[3] = bank_rdata3;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    mis = 1'b0;
    if (!is_vltype) begin
      unique case (load_select[1:0])
        2'd1:    mis = byte_offset[0];
        2'd2:    mis = |byte_offset;
        2'd3:    mis = |byte_offset;
        default: mis = 1'b0;
      endcase
    end
  end

  // A lane loses its turn to any lower, still-pending lane on its bank.
  always_comb begin
    grant = '0;
    for (int k = 0; k < 4; k++) begin
      if (state == S_ISSUE && pend[k]) begin
        grant[k] = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (pend[j] && la[j][1:0] == la[k][1:0])
            grant[k] = 1'b0;
        end
      end
    end
  end

  assign pend_nx = pend & ~grant;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_v[b]  = 1'b0;
      baddr[b] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (grant[k]) begin
        rd_v[la[k][1:0]]  = 1'b1;
        baddr[la[k][1:0]] = la[k][ADDR_W-1:2];
      end
    end
  end

  assign bank_rd0   = rd_v[0];
  assign bank_rd1   = rd_v[1];
  assign bank_rd2   = rd_v[2];
  assign bank_rd3   = rd_v[3];
  assign bank_addr0 = baddr[0];
  assign bank_addr1 = baddr[1];
  assign bank_addr2 = baddr[2];
  assign bank_addr3 = baddr[3];

  // Lane values including this cycle's capture, so the final group
  // can be folded straight into the response registers.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_nx[k] = iss_v[k] ? rdata[iss_bank[k]] : lane[k];
    end
  end

  always_comb begin
    sh  = lane_nx[0] >> {off_q, 3'b000};
    ext = sh;
    unique case (lsel_q[1:0])
      2'd0: ext = lsel_q[2] ? {24'd0, sh[7:0]}
                            : {{24{sh[7]}}, sh[7:0]};
      2'd1: ext = lsel_q[2] ? {16'd0, sh[15:0]}
                            : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = mis ? S_RESP : S_ISSUE;
      S_ISSUE: if (pend_nx == 4'b0000) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vec_q    <= 1'b0;
      lsel_q   <= '0;
      off_q    <= '0;
      pend     <= '0;
      iss_v    <= '0;
      resp_err <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        la[k]       <= '0;
        iss_bank[k] <= '0;
        lane[k]     <= '0;
        rsp[k]      <= '0;
      end
    end else begin
      iss_v <= grant;
      for (int k = 0; k < 4; k++) begin
        iss_bank[k] <= la[k][1:0];
      end
      if (accept) begin
        vec_q  <= is_vltype;
        lsel_q <= load_select;
        off_q  <= byte_offset;
        la[0]  <= addr0;
        la[1]  <= addr1;
        la[2]  <= addr2;
        la[3]  <= addr3;
        if (is_vltype)
          pend <= 4'b1111;
        else
          pend <= mis ? 4'b0000 : 4'b0001;
        for (int k = 0; k < 4; k++) begin
          lane[k] <= '0;
        end
      end else begin
        pend <= pend_nx;
        for (int k = 0; k < 4; k++) begin
          lane[k] <= lane_nx[k];
        end
      end
      if (accept && mis) begin
        resp_err <= 1'b1;
        for (int k = 0; k < 4; k++) begin
          rsp[k] <= '0;
        end
      end else if (state == S_DRAIN) begin
        resp_err <= 1'b0;
        if (vec_q) begin
          for (int k = 0; k < 4; k++) begin
            rsp[k] <= lane_nx[k];
          end
        end else begin
          rsp[0] <= ext;
          rsp[1] <= '0;
          rsp[2] <= '0;
          rsp[3] <= '0;
        end
      end
    end
  end

  assign resp_data0 = rsp[0];
  assign resp_data1 = rsp[1];
  assign resp_data2 = rsp[2];
  assign resp_data3 = rsp[3];

endmodule

// File: doc/load_gather_unit.md
# load_gather_unit

Data-memory read path of the banked 4-bank data memory, the load-side counterpart to the store path. It accepts a scalar load or a 4-lane vector load and issues bank reads, serializing lanes that collide on the same bank. It captures the synchronous-read data, then returns sign- or zero-extended scalar data, or four gathered words to the VLSU. It sits between the MEM stage / VLSU and the four data-memory banks.

## Interface
- ADDR_W, `DATAMEM_BITS: element address width. addr[1:0] selects the bank; addr[ADDR_W-1:2] is the in-bank word address.

- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- is_vltype  in  1  1 = vector load (4 lanes, word each); 0 = scalar load (lane 0 only)
- load_select  in  3  scalar only: [1:0] size (0 = byte, 1 = half, 2 = word, 3 = treated as word); [2] unsigned
- byte_offset  in  2  scalar only: byte position within the 32-bit bank word
- addr0..addr3  in  ADDR_W each  lane addresses; addr1..3 ignored when is_vltype = 0
- bank_rd0..bank_rd3  out  1 each  read strobe per bank
- bank_addr0..bank_addr3  out  ADDR_W-2 each  in-bank address, valid while the matching strobe is high
- bank_rdata0..bank_rdata3  in  32 each  read data, valid the cycle after the strobe
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  misaligned scalar request; qualified by resp_valid
- resp_data0..resp_data3  out  32 each  response data; scalar result in resp_data0

## Operation
- Request capture: on req_valid && req_ready, all request fields are registered and the unit leaves IDLE.
- Pending mask:
  - Vector requests set it to 4'b1111.
  - Scalar requests set it to 4'b0001.
  - Misaligned scalar requests set it to 4'b0000.
- Misaligned cases:
  - Half with byte_offset = 1 or 3.
  - Word with byte_offset != 0.
  - A misaligned request issues no bank read, and the response carries resp_err = 1 with all data zero.
- Grant rule, per ISSUE cycle: a pending lane is granted if no lower-numbered pending lane targets the same bank. Lane 0 has the highest priority.
  - The bank for lane k is addr_k[1:0].
  - Granted lanes drive bank_rd/bank_addr of their bank and are cleared from the pending mask.
- Capture: the cycle after an issue, each lane issued in the prior cycle loads its bank's bank_rdata into its lane register. A registered issued-lane/bank record steers the capture. Issue and capture overlap.
- Scalar extraction: word = rdata >> (8*byte_offset), using the store path's lane placement (byte k at bits [8k+7:8k]).
  - Byte result: sign-extend bit 7, or zero-extend if unsigned.
  - Half result: sign-extend bit 15, or zero-extend if unsigned.
  - Word result: passed through unchanged.
  - resp_data1..3 = 0 for scalar responses.
- Vector: no extension; lane k's word goes to resp_data_k.
- FSM:
  - IDLE: req_ready = 1. On accept, go to ISSUE, or to RESP if misaligned.
  - ISSUE: grant and issue. Once the pending mask becomes empty after this cycle's grants, go to DRAIN.
  - DRAIN: capture the last group, then go to RESP.
  - RESP: resp_valid = 1, then go to IDLE.
- resp_data/resp_err hold their values until the next RESP. There is no response back-pressure.

## Timing
- Accept in cycle 0:
  - Conflict-free request: issue in cycle 1, capture in cycle 2, resp_valid in cycle 3.
  - Each extra grant round adds one cycle.
  - Worst case (all 4 lanes on one bank): issues in cycles 1–4, resp_valid in cycle 6.
  - Misaligned request: resp_valid in cycle 1.
- Requests are never overlapped; req_ready = 0 from cycle 1 until the cycle after RESP.
- Reset (asynchronous, any state):
  - State returns to IDLE; the pending mask and lane registers are cleared.
  - req_ready = 1.
  - resp_valid, resp_err, all bank_rd = 0.
  - bank_addr*, resp_data* = 0.
- Requests must be re-issued after reset; the unit does not capture read data that returns after reset.
- bank_rd* is low in every state except ISSUE, and is low in ISSUE for banks that have no grant.

## Test plan
- Scalar signed byte: addr0 bank 2, byte_offset 3, load_select 3'b000, bank_rdata2 = 0x80112233 → cycle 1 bank_rd2 only; cycle 3 resp_data0 = 0xFFFFFF80, resp_err = 0. Same request with load_select 3'b100 → 0x00000080.
- Scalar half: byte_offset 2, load_select 3'b001, rdata 0x12345678 → 0x00001234. Same request with rdata 0x8765xxxx → 0xFFFF8765.
- Misaligned word: load_select 3'b010, byte_offset 1 → no bank_rd ever asserted; cycle 1 resp_valid = 1, resp_err = 1, data 0.
- Vector, distinct banks (addr[1:0] = 0,1,2,3): all four strobes asserted in cycle 1; resp_valid in cycle 3; resp_data_k equals the programmed bank_k words.
- Vector, all lanes on bank 1 (in-bank addresses 5, 6, 7, 8): bank_rd1 high in cycles 1–4 with bank_addr1 = 5, 6, 7, 8 in order; resp_valid in cycle 6; lane data correctly ordered. Mixed case (lanes 0 and 2 on bank 0, lanes 1 and 3 on banks 1 and 3) → 2 rounds, resp_valid in cycle 4.
- Reset mid-operation: assert nrst low in cycle 2 of the all-same-bank case → outputs at their reset values immediately, no resp_valid afterwards; a new request after release completes normally.
